tree_out_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for one output port of a tree router node; the input

---
 rtl/tree_noc_pkg.sv | 21 ++
 rtl/rr_pick.sv | 29 ++
 rtl/tree_out_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tree_out_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tree_noc_pkg.sv
// Shared packet layout, FSM state type and legality helper for the tree router output arbiter.
// Packet layout: [addr | dest | payload], addr in the MSBs.
package tree_noc_pkg;

   localparam int unsigned PKT_W     = 14;
   localparam int unsigned ADDR_W    = 3;
   localparam int unsigned DEST_W    = 3;
   localparam int unsigned PAYLOAD_W = PKT_W - ADDR_W - DEST_W;
   localparam int unsigned ADDR_LSB  = PKT_W - ADDR_W;
   localparam int unsigned DEST_LSB  = ADDR_LSB - DEST_W;

   typedef logic [PKT_W-1:0] pkt_t;

   typedef enum logic [1:0] {IDLE, LAT, SEND, COOL} arb_state_t;

   // A packet addressed back to its own source is illegal and gets dropped.
   function automatic logic is_illegal(pkt_t pkt);
      return pkt[ADDR_LSB +: ADDR_W] == pkt[DEST_LSB +: DEST_W];
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int unsigned j;
      j   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         j = (32'(ptr) + k) % NUM_REQ;
         if (!any && req[j]) begin
            any    = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/tree_out_arbiter.sv
// Round-robin arbiter/sequencer for one tree router output port with forward latency FL and
// post-handshake cool-down BL. Define TREE_ARB_STATS_EN to add grant_cnt/drop_cnt outputs.
module tree_out_arbiter
   import tree_noc_pkg::*;
#(
   parameter int unsigned WIDTH_packet = 14,
   parameter int unsigned WIDTH_addr   = 3,
   parameter int unsigned WIDTH_dest   = 3,
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned FL           = 2,
   parameter int unsigned BL           = 1,
   localparam int unsigned IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              in_valid,
   input  logic [NUM_REQ*WIDTH_packet-1:0] in_data,
   output logic [NUM_REQ-1:0]              in_ready,
   output logic                            out_valid,
   output logic [WIDTH_packet-1:0]         out_data,
   input  logic                            out_ready,
   output logic [IW-1:0]                   grant_id,
`ifdef TREE_ARB_STATS_EN
   output logic [NUM_REQ*16-1:0]           grant_cnt,
   output logic [15:0]                     drop_cnt,
`endif
   output logic                            drop_pulse
);

   if (FL > 15) begin : g_fl_range_err
      $error("FL must be in 0..15");
   end
   if (BL > 15) begin : g_bl_range_err
      $error("BL must be in 0..15");
   end
   if (NUM_REQ < 2) begin : g_num_req_err
      $error("NUM_REQ must be at least 2");
   end
   if (WIDTH_packet != PKT_W || WIDTH_addr != ADDR_W || WIDTH_dest != DEST_W)
   begin : g_layout_err
      $error("packet layout must match tree_noc_pkg");
   end

   localparam logic [3:0] FL4 = 4'(FL);
   localparam logic [3:0] BL4 = 4'(BL);

   arb_state_t    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [IW-1:0] rr_ptr_q, grant_id_q;
   pkt_t          data_q;
   logic          drop_q;

   logic [NUM_REQ-1:0] pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_any;
   pkt_t               win_pkt;
   logic               win_illegal, accept, handshake;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IW)
   ) u_rr_pick (
      .req (in_valid),
      .ptr (rr_ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx),
      .any (pick_any)
   );

   assign win_pkt     = in_data[pick_idx*WIDTH_packet +: WIDTH_packet];
   assign win_illegal = is_illegal(win_pkt);
   assign accept      = (state_q == IDLE) && pick_any && !rst;
   assign handshake   = (state_q == SEND) && out_ready;

   assign in_ready   = accept ? pick_gnt : '0;
   assign out_valid  = (state_q == SEND);
   assign out_data   = data_q;
   assign grant_id   = grant_id_q;
   assign drop_pulse = drop_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               // Dropped packets still pay the cool-down so spacing is uniform.
               if (win_illegal) begin
                  if (BL4 != 4'd0) begin
                     state_d = COOL;
                     cnt_d   = BL4;
                  end
               end else if (FL4 == 4'd0) begin
                  state_d = SEND;
               end else begin
                  state_d = LAT;
                  cnt_d   = FL4;
               end
            end
         end
         LAT: begin
            if (cnt_q == 4'd1) state_d = SEND;
            else cnt_d = cnt_q - 4'd1;
         end
         SEND: begin
            if (out_ready) begin
               if (BL4 == 4'd0) begin
                  state_d = IDLE;
               end else begin
                  state_d = COOL;
                  cnt_d   = BL4;
               end
            end
         end
         COOL: begin
            if (cnt_q == 4'd1) state_d = IDLE;
            else cnt_d = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         data_q     <= '0;
         drop_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         drop_q  <= accept && win_illegal;
         if (accept) begin
            data_q     <= win_pkt;
            grant_id_q <= pick_idx;
            rr_ptr_q   <= (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
         end
      end
   end

`ifdef TREE_ARB_STATS_EN
   logic [NUM_REQ*16-1:0] grant_cnt_q;
   logic [15:0]           drop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         if (handshake && grant_cnt_q[grant_id_q*16 +: 16] != 16'hFFFF) begin
            grant_cnt_q[grant_id_q*16 +: 16] <= grant_cnt_q[grant_id_q*16 +: 16] + 16'd1;
         end
         if (accept && win_illegal && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   assign grant_cnt = grant_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tree_out_arbiter.sv
// Randomized bench for tree_out_arbiter against a transaction-timing reference model.
module tb_tree_out_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned W    = 14;
   localparam int unsigned FLP  = 2;
   localparam int unsigned BLP  = 1;
   localparam int unsigned IW   = $clog2(NREQ);

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic [NREQ-1:0]     in_valid = '0;
   logic [NREQ*W-1:0]   in_data = '0;
   logic [NREQ-1:0]     in_ready;
   logic                out_valid;
   logic [W-1:0]        out_data;
   logic                out_ready = 1'b0;
   logic [IW-1:0]       grant_id;
   logic                drop_pulse;
`ifdef TREE_ARB_STATS_EN
   logic [NREQ*16-1:0]  grant_cnt;
   logic [15:0]         drop_cnt;
`endif

   tree_out_arbiter #(
      .WIDTH_packet (W),
      .WIDTH_addr   (3),
      .WIDTH_dest   (3),
      .NUM_REQ      (NREQ),
      .FL           (FLP),
      .BL           (BLP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .grant_id   (grant_id),
`ifdef TREE_ARB_STATS_EN
      .grant_cnt  (grant_cnt),
      .drop_cnt   (drop_cnt),
`endif
      .drop_pulse (drop_pulse)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Requester queues; the head is presented while non-empty.
   logic [W-1:0] rq0[$];
   logic [W-1:0] rq1[$];

   // Reference model: when the port is free, when the held packet appears, pending drop.
   int           ptr = 0;
   int           free_at = 0;
   int           show_at = 0;
   int           drop_at = -1;
   bit           have_pkt = 0;
   logic [W-1:0] m_pkt = '0;
   int           m_gid = 0;
   int           rst_run = 0;
   int           fwd_cnt[NREQ];
   int           drp_cnt = 0;

   function automatic logic [W-1:0] rand_pkt();
      logic [2:0] a, d;
      logic [7:0] p;
      a = 3'($urandom_range(7));
      d = ($urandom_range(3) == 0) ? a : 3'($urandom_range(7));
      p = 8'($urandom);
      return {a, d, p};
   endfunction

   task automatic step(input bit do_rst, input int unsigned ready_pct);
      int           win;
      int           j;
      logic [W-1:0] pkt;
      logic [NREQ-1:0] exp_rdy;
      bit           exp_ov;
      @(negedge clk);
      rst       = do_rst;
      out_ready = ($urandom_range(99) < ready_pct);
      in_valid  = {rq1.size() > 0, rq0.size() > 0};
      in_data   = '0;
      if (rq0.size() > 0) in_data[0 +: W] = rq0[0];
      if (rq1.size() > 0) in_data[W +: W] = rq1[0];
      #1;
      if (do_rst) begin
         check("rst_in_ready", 32'(in_ready), 32'd0);
         if (rst_run > 0) begin
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_grant_id", 32'(grant_id), 32'd0);
         end
         rst_run++;
         have_pkt = 0;
         free_at  = cyc + 1;
         ptr      = 0;
         drop_at  = -1;
         drp_cnt  = 0;
         for (int i = 0; i < NREQ; i++) fwd_cnt[i] = 0;
      end else begin
         rst_run = 0;
         exp_ov = have_pkt && (cyc >= show_at);
         check("out_valid", 32'(out_valid), 32'(exp_ov));
         if (exp_ov) begin
            check("out_data", 32'(out_data), 32'(m_pkt));
            check("grant_id", 32'(grant_id), 32'(m_gid));
         end
         check("drop_pulse", 32'(drop_pulse), 32'(cyc == drop_at));
         win = -1;
         if (!have_pkt && cyc >= free_at) begin
            for (int k = 0; k < NREQ; k++) begin
               j = (ptr + k) % NREQ;
               if (win < 0 && in_valid[j]) win = j;
            end
         end
         exp_rdy = '0;
         if (win >= 0) exp_rdy[win] = 1'b1;
         check("in_ready", 32'(in_ready), 32'(exp_rdy));
         if (exp_ov && out_ready) begin
            have_pkt = 0;
            free_at  = cyc + 1 + BLP;
            fwd_cnt[m_gid]++;
         end
         if (win >= 0) begin
            pkt = (win == 0) ? rq0[0] : rq1[0];
            ptr = (win + 1) % NREQ;
            if (pkt[13:11] == pkt[10:8]) begin
               drop_at = cyc + 1;
               free_at = cyc + 1 + BLP;
               drp_cnt++;
            end else begin
               have_pkt = 1;
               m_pkt    = pkt;
               m_gid    = win;
               show_at  = cyc + 1 + FLP;
            end
         end
      end
      // Requesters react to what the DUT actually granted.
      if (in_ready[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (in_ready[1] && rq1.size() > 0) void'(rq1.pop_front());
      cyc++;
   endtask

   initial begin
      bit reached;
      for (int i = 0; i < NREQ; i++) fwd_cnt[i] = 0;

      // Reset held with both requesters valid.
      rq0.push_back(14'b000_011_00000001);
      rq1.push_back(14'b001_010_00000010);
      for (int i = 0; i < 3; i++) step(1'b1, 100);

      // Both requesters competing, out_ready tied high: alternating grants.
      for (int i = 0; i < 3; i++) begin
         rq0.push_back(14'b000_011_00000001);
         rq1.push_back(14'b001_010_00000010);
      end
      for (int i = 0; i < 45; i++) step(1'b0, 100);

      // Only requester 1: served every FL+2+BL cycles, pointer wraps.
      for (int i = 0; i < 4; i++) rq1.push_back(14'b001_010_00000011 + 14'(i));
      for (int i = 0; i < 25; i++) step(1'b0, 100);

      // Illegal packet: drop pulse, no output.
      rq0.push_back(14'b101_101_01010101);
      for (int i = 0; i < 6; i++) step(1'b0, 100);

      // Back-pressure in SEND.
      rq0.push_back(14'b010_100_11110000);
      rq1.push_back(14'b011_001_00001111);
      for (int i = 0; i < 4; i++) step(1'b0, 100);
      for (int i = 0; i < 10; i++) step(1'b0, 0);
      for (int i = 0; i < 12; i++) step(1'b0, 100);

      // Reset while the packet sits in the latency stage.
      rq0.push_back(14'b110_000_10101010);
      reached = 0;
      for (int k = 0; k < 12 && !reached; k++) begin
         if (have_pkt && cyc < show_at) reached = 1;
         else step(1'b0, 100);
      end
      check("lat_reached", 32'(reached), 32'd1);
      step(1'b1, 100);
      for (int i = 0; i < 8; i++) step(1'b0, 100);

      // Random traffic, back-pressure and occasional resets.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(2) == 0) begin
            if ($urandom_range(1) == 0) begin
               if (rq0.size() < 4) rq0.push_back(rand_pkt());
            end else begin
               if (rq1.size() < 4) rq1.push_back(rand_pkt());
            end
         end
         step($urandom_range(149) == 0, 70);
      end
      for (int i = 0; i < 60; i++) step(1'b0, 100);

`ifdef TREE_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++) begin
         check("grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'(fwd_cnt[i]));
      end
      check("drop_cnt", 32'(drop_cnt), 32'(drp_cnt));
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
